// File: rtl/thermo_decoder_pipe.sv
// thermo_decoder_pipe: pipelined thermometer-code decoder with a valid/ready stream.
// Checks an N-bit LSB-first thermometer code for legality and presents a registered
// one-hot line select (per-transaction polarity), a binary level and a legality flag.
// A saturating counter tracks accepted illegal codes.
//
// Build option: define THERMO_DECODER_BUBBLE_CORRECT_EN to decode illegal (bubbled)
// codes by population count instead of forcing level 0 / no active line.
module thermo_decoder_pipe #(
  parameter int unsigned N     = 7,
  parameter int unsigned ERR_W = 8,
  localparam int unsigned LW   = $clog2(N + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic             active_low,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N:0]       y,
  output logic [LW-1:0]    level,
  output logic             code_ok,
  output logic [ERR_W-1:0] err_count,
  input  logic             err_clear
);

  localparam logic [ERR_W-1:0] ErrMax = {ERR_W{1'b1}};

  logic             out_valid_q, out_valid_d;
  logic [N:0]       y_q, y_d;
  logic [LW-1:0]    level_q, level_d;
  logic             code_ok_q, code_ok_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic             accept;
  logic [N:0]       a_ext;
  logic             dec_legal;
  logic [LW-1:0]    dec_pop;
  logic [LW-1:0]    dec_level;
  logic [N:0]       dec_onehot;

  // Single register stage without a skid buffer: ready whenever the slot is free or draining.
  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  // Legality and level decode of the incoming code.
  always_comb begin
    a_ext     = {1'b0, a};
    // (2^k)-1 is exactly the set of values with no carry overlap when incremented.
    dec_legal = ((a_ext + (N + 1)'(1)) & a_ext) == '0;
    dec_pop   = '0;
    for (int i = 0; i < int'(N); i++) begin
      dec_pop = dec_pop + LW'(a[i]);
    end
`ifdef THERMO_DECODER_BUBBLE_CORRECT_EN
    // Bubbled codes snap to the level given by their count of ones.
    dec_level  = dec_pop;
    dec_onehot = (N + 1)'(1) << dec_pop;
`else
    // Bubbled codes select no line and report level 0.
    dec_level  = dec_legal ? dec_pop : '0;
    dec_onehot = dec_legal ? ((N + 1)'(1) << dec_pop) : '0;
`endif
  end

  // Next state of the output stage and the error counter.
  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    level_d     = level_q;
    code_ok_d   = code_ok_q;
    err_d       = err_q;

    if (accept) begin
      out_valid_d = 1'b1;
      y_d         = dec_onehot ^ {(N + 1){active_low}};
      level_d     = dec_level;
      code_ok_d   = dec_legal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept && !dec_legal) begin
      // A clear in the same cycle as an illegal accept still records that accept.
      if (err_clear) begin
        err_d = ERR_W'(1);
      end else if (err_q != ErrMax) begin
        err_d = err_q + ERR_W'(1);
      end
    end else if (err_clear) begin
      err_d = '0;
    end
  end

  // State registers with synchronous reset; reset discards any pending transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      level_q     <= '0;
      code_ok_q   <= 1'b0;
      err_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      level_q     <= level_d;
      code_ok_q   <= code_ok_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign level     = level_q;
  assign code_ok   = code_ok_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_thermo_decoder_pipe.sv
// Self-checking bench for thermo_decoder_pipe (N=7, ERR_W=2): directed vector table
// followed by randomized traffic checked against a behavioural model.
module tb_thermo_decoder_pipe;

  localparam int N     = 7;
  localparam int ERR_W = 2;
`ifdef THERMO_DECODER_BUBBLE_CORRECT_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a;
  logic             active_low;
  logic             out_valid;
  logic             out_ready;
  logic [N:0]       y;
  logic [2:0]       level;
  logic             code_ok;
  logic [ERR_W-1:0] err_count;
  logic             err_clear;

  int vectors     = 0;
  int miscompares = 0;

  thermo_decoder_pipe #(.N(N), .ERR_W(ERR_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .active_low(active_low),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .level     (level),
    .code_ok   (code_ok),
    .err_count (err_count),
    .err_clear (err_clear)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       inv;
    logic [6:0] av;
    logic       al;
    logic       ordy;
    logic       clr;
    logic       erdy;
    logic       ev;
    logic [7:0] ey;
    int         el;
    logic       eok;
    int         eerr;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model state
  logic m_v;
  logic [7:0] m_y;
  int m_l;
  logic m_ok;
  int m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic inv, input logic [6:0] av, input logic al,
                     input logic ordy, input logic clr, input logic erdy, input logic ev,
                     input logic [7:0] ey, input int el, input logic eok, input int eerr);
    vec_t v;
    v.rst = rst; v.inv = inv; v.av = av; v.al = al; v.ordy = ordy; v.clr = clr;
    v.erdy = erdy; v.ev = ev; v.ey = ey; v.el = el; v.eok = eok; v.eerr = eerr;
    tbl.push_back(v);
  endtask

  // Reference decode straight from the code rules: legal iff value is 2^k-1.
  function automatic void ref_decode(input logic [6:0] av, input logic al,
                                     output logic [7:0] yy, output int lv, output logic ok);
    logic [7:0] oh;
    ok = 1'b0;
    for (int k = 0; k <= N; k++) if (int'(av) == (1 << k) - 1) ok = 1'b1;
    lv = (ok || BC) ? $countones(av) : 0;
    oh = (ok || BC) ? 8'(1 << lv) : 8'h00;
    yy = oh ^ {8{al}};
  endfunction

  task automatic model_step(input logic rst, input logic inv, input logic [6:0] av,
                            input logic al, input logic ordy, input logic clr);
    logic acc, ok;
    logic [7:0] yy;
    int lv;
    if (rst) begin
      m_v = 0; m_y = '0; m_l = 0; m_ok = 0; m_err = 0;
      return;
    end
    acc = inv && (!m_v || ordy);
    ref_decode(av, al, yy, lv, ok);
    if (acc) begin
      m_v = 1; m_y = yy; m_l = lv; m_ok = ok;
    end else if (ordy) begin
      m_v = 0;
    end
    if (acc && !ok) m_err = clr ? 1 : ((m_err < (1 << ERR_W) - 1) ? m_err + 1 : m_err);
    else if (clr) m_err = 0;
  endtask

  task automatic drive(input logic rst, input logic inv, input logic [6:0] av, input logic al,
                       input logic ordy, input logic clr);
    reset = rst; in_valid = inv; a = av; active_low = al; out_ready = ordy; err_clear = clr;
  endtask

  initial begin
    logic rr, iv, al, orr, cl;
    logic [6:0] av;
    logic was_rst;

    drive(1, 0, '0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;

    // Directed table: inputs for one clock, expected in_ready before the edge and outputs after.
    add(1, 0, 7'h00, 0, 1, 0, 1, 0, 8'h00, 0, 0, 0);
    add(0, 1, 7'b0000111, 0, 1, 0, 1, 1, 8'b0000_1000, 3, 1, 0);
    add(0, 1, 7'b0000000, 1, 1, 0, 1, 1, 8'b1111_1110, 0, 1, 0);
    add(0, 1, 7'b1111111, 1, 1, 0, 1, 1, 8'b0111_1111, 7, 1, 0);
    add(0, 0, 7'b0000000, 0, 1, 0, 1, 0, 8'h00, 0, 0, 0);
    // Backpressure
    add(0, 1, 7'b0000001, 0, 0, 0, 1, 1, 8'b0000_0010, 1, 1, 0);
    add(0, 1, 7'b0000011, 0, 0, 0, 0, 1, 8'b0000_0010, 1, 1, 0);
    add(0, 1, 7'b0000011, 0, 0, 0, 0, 1, 8'b0000_0010, 1, 1, 0);
    add(0, 1, 7'b0000011, 0, 1, 0, 1, 1, 8'b0000_0100, 2, 1, 0);
    add(0, 0, 7'b0000000, 0, 1, 0, 1, 0, 8'h00, 0, 0, 0);
    // Illegal codes and counter saturation
    add(0, 1, 7'b0000101, 0, 1, 0, 1, 1, BC ? 8'b0000_0100 : 8'h00, BC ? 2 : 0, 0, 1);
    add(0, 1, 7'b0000110, 1, 1, 0, 1, 1, BC ? 8'b1111_1011 : 8'hFF, BC ? 2 : 0, 0, 2);
    add(0, 1, 7'b1010101, 0, 1, 0, 1, 1, BC ? 8'b0001_0000 : 8'h00, BC ? 4 : 0, 0, 3);
    add(0, 1, 7'b0000010, 0, 1, 0, 1, 1, BC ? 8'b0000_0010 : 8'h00, BC ? 1 : 0, 0, 3);
    add(0, 1, 7'b1111110, 0, 1, 0, 1, 1, BC ? 8'b0100_0000 : 8'h00, BC ? 6 : 0, 0, 3);
    add(0, 1, 7'b0100000, 0, 1, 1, 1, 1, BC ? 8'b0000_0010 : 8'h00, BC ? 1 : 0, 0, 1);
    add(0, 0, 7'b0000000, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0);
    // Reset mid-stream with a pending transaction and a new offer
    add(0, 1, 7'b0000101, 1, 0, 0, 1, 1, BC ? 8'b1111_1011 : 8'hFF, BC ? 2 : 0, 0, 1);
    add(1, 1, 7'b0001111, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    add(0, 1, 7'b0011111, 0, 1, 0, 1, 1, 8'b0010_0000, 5, 1, 0);
    add(0, 0, 7'b0000000, 0, 1, 0, 1, 0, 8'h00, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].inv, tbl[i].av, tbl[i].al, tbl[i].ordy, tbl[i].clr);
      #3;
      if (!tbl[i].rst) chk($sformatf("tbl%0d in_ready", i), 32'(in_ready), 32'(tbl[i].erdy));
      @(posedge clock);
      #1;
      chk($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d err_count", i), 32'(err_count), 32'(tbl[i].eerr));
      if (tbl[i].ev || tbl[i].rst) begin
        chk($sformatf("tbl%0d y", i), 32'(y), 32'(tbl[i].ey));
        chk($sformatf("tbl%0d level", i), 32'(level), 32'(tbl[i].el));
        chk($sformatf("tbl%0d code_ok", i), 32'(code_ok), 32'(tbl[i].eok));
      end
    end

    // Randomized traffic against the model, starting from reset
    model_step(1, 0, '0, 0, 0, 0);
    drive(1, 0, '0, 0, 0, 0);
    @(posedge clock);
    #1;
    for (int c = 0; c < 3000; c++) begin
      rr  = ($urandom_range(0, 99) == 0);
      iv  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) av = 7'((1 << $urandom_range(0, N)) - 1);
      else av = 7'($urandom);
      al  = 1'($urandom);
      orr = ($urandom_range(0, 9) < 7);
      cl  = ($urandom_range(0, 19) == 0);
      drive(rr, iv, av, al, orr, cl);
      #3;
      if (!rr) chk("rnd in_ready", 32'(in_ready), 32'(!m_v || orr));
      @(posedge clock);
      model_step(rr, iv, av, al, orr, cl);
      was_rst = rr;
      #1;
      chk("rnd out_valid", 32'(out_valid), 32'(m_v));
      chk("rnd err_count", 32'(err_count), 32'(m_err));
      if (m_v || was_rst) begin
        chk("rnd y", 32'(y), 32'(m_y));
        chk("rnd level", 32'(level), 32'(m_l));
        chk("rnd code_ok", 32'(code_ok), 32'(m_ok));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
